// File: rtl/inst_queue_param.sv
// Parametrised instruction/PC queue between fetch and decode, with early-full warning and flush.
// Optional same-cycle bypass into the output registers when empty: define IQ_BYPASS_EN.
module inst_queue_param #(
    parameter int unsigned INST_WIDTH  = 32,
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned DEPTH_LOG2  = 3,
    parameter int unsigned FULL_MARGIN = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [INST_WIDTH-1:0] inst_if_in,
    input  logic [PC_WIDTH-1:0]   pc_if_in,
    input  logic                  inst_rdy_if_in,
    output logic                  iqfull_if_out,
    input  logic                  flush_in,
    input  logic                  rs_full_rs_in,
    input  logic                  rob_full_rob_in,
    output logic [INST_WIDTH-1:0] inst_dec_out,
    output logic [PC_WIDTH-1:0]   pc_dec_out,
    output logic                  rdy_dec_out,
    output logic [DEPTH_LOG2:0]   count_out
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [INST_WIDTH-1:0] inst_mem [DEPTH];
    logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];

    logic [DEPTH_LOG2-1:0] head;
    logic [DEPTH_LOG2-1:0] tail;
    logic [CW-1:0]         count;

    logic stall_c;
    logic empty_c;
    logic full_c;
    logic pop_c;
    logic bypass_c;
    logic push_c;
    logic wr_en_c;

    assign stall_c = rs_full_rs_in || rob_full_rob_in;
    assign empty_c = (count == CW'(0));
    assign full_c  = (count == CW'(DEPTH));
    assign pop_c   = !empty_c && !stall_c;

`ifdef IQ_BYPASS_EN
    // Empty queue and free decoder: the incoming word goes straight to the output registers.
    assign bypass_c = inst_rdy_if_in && empty_c && !stall_c && !flush_in;
`else
    assign bypass_c = 1'b0;
`endif

    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign push_c  = inst_rdy_if_in && (!full_c || pop_c) && !bypass_c;
    assign wr_en_c = rdy_in && !rst_in && !flush_in && push_c;

    assign iqfull_if_out = (count >= CW'(DEPTH - FULL_MARGIN));
    assign count_out     = count;

    always_ff @(posedge clk_in) begin
        if (wr_en_c) begin
            inst_mem[tail] <= inst_if_in;
            pc_mem[tail]   <= pc_if_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            rdy_dec_out  <= 1'b0;
            inst_dec_out <= '0;
            pc_dec_out   <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                rdy_dec_out <= 1'b0;
            end else begin
                if (push_c) begin
                    tail <= tail + 1'b1;
                end
                if (pop_c) begin
                    head <= head + 1'b1;
                end
                case ({push_c, pop_c})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                rdy_dec_out <= pop_c || bypass_c;
                if (pop_c) begin
                    inst_dec_out <= inst_mem[head];
                    pc_dec_out   <= pc_mem[head];
                end else if (bypass_c) begin
                    inst_dec_out <= inst_if_in;
                    pc_dec_out   <= pc_if_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_queue_param.sv
// Scoreboard bench for inst_queue_param (depth 8, margin 1); honours IQ_BYPASS_EN for latency.
module tb_inst_queue_param;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] inst_if_in;
    logic [31:0] pc_if_in;
    logic        inst_rdy_if_in;
    logic        iqfull_if_out;
    logic        flush_in;
    logic        rs_full_rs_in;
    logic        rob_full_rob_in;
    logic [31:0] inst_dec_out;
    logic [31:0] pc_dec_out;
    logic        rdy_dec_out;
    logic [3:0]  count_out;

`ifdef IQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [63:0] sb [$];

    inst_queue_param #(
        .INST_WIDTH(32), .PC_WIDTH(32), .DEPTH_LOG2(3), .FULL_MARGIN(1)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .inst_if_in(inst_if_in), .pc_if_in(pc_if_in), .inst_rdy_if_in(inst_rdy_if_in),
        .iqfull_if_out(iqfull_if_out), .flush_in(flush_in),
        .rs_full_rs_in(rs_full_rs_in), .rob_full_rob_in(rob_full_rob_in),
        .inst_dec_out(inst_dec_out), .pc_dec_out(pc_dec_out),
        .rdy_dec_out(rdy_dec_out), .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One active edge; inputs change and outputs are checked on the falling edge.
    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic drive_push(input logic [31:0] inst, input logic [31:0] pc, input bit expect_store);
        inst_rdy_if_in = 1'b1;
        inst_if_in     = inst;
        pc_if_in       = pc;
        if (expect_store) sb.push_back({inst, pc});
    endtask

    // Monitor: every enabled edge that leaves rdy_dec_out high is one issued entry.
    initial begin
        logic en;
        logic [63:0] exp;
        forever begin
            @(posedge clk_in);
            en = rdy_in;
            #1;
            if (en && rdy_dec_out) begin
                if (sb.size() == 0) begin
                    check("unexpected_issue", {inst_dec_out, pc_dec_out}, 64'h0);
                    if ({inst_dec_out, pc_dec_out} == 64'h0) begin
                        errors++;
                        $display("FAIL unexpected_issue actual=%h required=none", {inst_dec_out, pc_dec_out});
                    end
                end else begin
                    exp = sb.pop_front();
                    check("issue_order", {inst_dec_out, pc_dec_out}, exp);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        rst_in = 1'b1; rdy_in = 1'b1; inst_if_in = '0; pc_if_in = '0;
        inst_rdy_if_in = 1'b0; flush_in = 1'b0; rs_full_rs_in = 1'b0; rob_full_rob_in = 1'b0;
        tick(); tick();
        check("reset_count", 64'(count_out), 64'd0);
        check("reset_rdy", 64'(rdy_dec_out), 64'd0);
        check("reset_data", {inst_dec_out, pc_dec_out}, 64'd0);
        check("reset_iqfull", 64'(iqfull_if_out), 64'd0);
        rst_in = 1'b0;

        // First push after reset: latency 2, or 1 with bypass
        drive_push(32'h0000_0013, 32'h0, 1'b1);
        tick();
        inst_rdy_if_in = 1'b0;
        check("first_lat_edge1", 64'(rdy_dec_out), 64'(BYP));
        tick();
        check("first_lat_edge2", 64'(rdy_dec_out), 64'(!BYP));
        check("first_count", 64'(count_out), 64'd0);

        // Fill with issue stalled
        rs_full_rs_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_push(32'hA000_0000 + 32'(i), 32'h100 + 32'(4 * i), 1'b1);
            tick();
            check("fill_count", 64'(count_out), 64'(i + 1));
            check("fill_iqfull", 64'(iqfull_if_out), 64'(i + 1 >= 7));
        end
        drive_push(32'hDEAD_BEEF, 32'hFFF0, 1'b0);
        tick();
        check("drop_count", 64'(count_out), 64'd8);

        // Push and pop together at full, then drain on consecutive cycles
        rs_full_rs_in = 1'b0;
        drive_push(32'hB000_0000, 32'h200, 1'b1);
        tick();
        inst_rdy_if_in = 1'b0;
        check("full_pushpop_count", 64'(count_out), 64'd8);
        check("full_pushpop_rdy", 64'(rdy_dec_out), 64'd1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("drain_rdy", 64'(rdy_dec_out), 64'd1);
            check("drain_count", 64'(count_out), 64'(8 - k));
        end
        tick();
        check("drain_done_rdy", 64'(rdy_dec_out), 64'd0);

        // Flush with 5 stored and a push in the same cycle
        rs_full_rs_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_push(32'hC000_0000 + 32'(i), 32'h400 + 32'(4 * i), 1'b1);
            tick();
        end
        check("preflush_count", 64'(count_out), 64'd5);
        drive_push(32'hC000_0005, 32'h414, 1'b0);
        flush_in = 1'b1;
        sb.delete();
        tick();
        flush_in = 1'b0;
        inst_rdy_if_in = 1'b0;
        rs_full_rs_in = 1'b0;
        check("flush_count", 64'(count_out), 64'd0);
        check("flush_rdy", 64'(rdy_dec_out), 64'd0);
        check("flush_iqfull", 64'(iqfull_if_out), 64'd0);
        drive_push(32'hD000_0000, 32'h500, 1'b1);
        tick();
        inst_rdy_if_in = 1'b0;
        check("postflush_lat_edge1", 64'(rdy_dec_out), 64'(BYP));
        tick();
        check("postflush_lat_edge2", 64'(rdy_dec_out), 64'(!BYP));
        tick(); tick();

        // rdy_in low for 3 cycles mid-stream
        rs_full_rs_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_push(32'hE000_0000 + 32'(i), 32'h300 + 32'(4 * i), 1'b1);
            tick();
        end
        rs_full_rs_in = 1'b0;
        drive_push(32'hE000_0004, 32'h310, 1'b1);
        tick();
        check("stream_count", 64'(count_out), 64'd4);
        inst_if_in = 32'hE000_0005;
        pc_if_in   = 32'h314;
        rdy_in     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_count", 64'(count_out), 64'd4);
            check("hold_rdy", 64'(rdy_dec_out), 64'd1);
            check("hold_data", {inst_dec_out, pc_dec_out}, {32'hE000_0000, 32'h300});
        end
        rdy_in = 1'b1;
        drive_push(32'hE000_0005, 32'h314, 1'b1);
        tick();
        inst_rdy_if_in = 1'b0;
        check("resume_count", 64'(count_out), 64'd4);
        check("resume_data", {inst_dec_out, pc_dec_out}, {32'hE000_0001, 32'h304});

        wait_cycles = 0;
        while (sb.size() != 0 && wait_cycles < 50) begin
            tick();
            wait_cycles++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
        tick();
        check("final_count", 64'(count_out), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
